// File: rtl/bus_sequencer.sv
// Command sequencer driving a 4-entry register file through read/write selector buses.
// Executes MOV, LDI, SWAP and CLR as short read/write state sequences with registered bus outputs.
module bus_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [2:0]       cmd_src,
  input  logic [2:0]       cmd_dst,
  input  logic [WIDTH-1:0] cmd_imm,
  input  logic [WIDTH-1:0] src_data,
  output logic [2:0]       src_bus_selector,
  output logic [2:0]       dest_bus_selector,
  output logic [WIDTH-1:0] data,
  output logic             done,
  output logic             err,
  output logic [7:0]       xfer_count,
  output logic [2:0]       dbg_state
);

  // Handshake: a command transfers on a rising edge where cmd_valid and
  // cmd_ready are both 1; cmd_ready is 1 only in IDLE and never depends on cmd_valid.

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD_A = 3'd1,
    S_RD_B = 3'd2,
    S_WR_A = 3'd3,
    S_WR_B = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam logic [1:0] OP_MOV  = 2'b00;
  localparam logic [1:0] OP_LDI  = 2'b01;
  localparam logic [1:0] OP_SWAP = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  state_t state, state_n;

  logic [1:0]       op_q;
  logic [2:0]       src_q, dst_q;
  logic [WIDTH-1:0] imm_q;
  logic [WIDTH-1:0] tmp0, tmp1;
  logic [WIDTH-1:0] tmp0_n, tmp1_n;

  logic             accept;
  logic             cmd_bad;
  logic [1:0]       eff_op;
  logic [2:0]       eff_src, eff_dst;
  logic [WIDTH-1:0] eff_imm;

  logic [2:0]       src_sel_n, dest_sel_n;
  logic [WIDTH-1:0] data_n;
  logic             done_n, err_n;

  // Selector codes 3'b101..3'b111 do not name any register.
  function automatic logic sel_ok(input logic [2:0] s);
    return (s <= 3'b100);
  endfunction

  assign cmd_ready = (state == S_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign dbg_state = state;

  // Only the fields an op actually uses are validated.
  always_comb begin
    cmd_bad = 1'b0;
    case (cmd_op)
      OP_MOV, OP_SWAP: cmd_bad = !(sel_ok(cmd_src) && sel_ok(cmd_dst));
      default:         cmd_bad = !sel_ok(cmd_dst);
    endcase
  end

  // On the accept edge the latched fields are not yet loaded, so look through to the inputs.
  assign eff_op  = accept ? cmd_op  : op_q;
  assign eff_src = accept ? cmd_src : src_q;
  assign eff_dst = accept ? cmd_dst : dst_q;
  assign eff_imm = accept ? cmd_imm : imm_q;

  assign tmp0_n = (state == S_RD_A) ? src_data : tmp0;
  assign tmp1_n = (state == S_RD_B) ? src_data : tmp1;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: begin
        if (cmd_valid && !cmd_bad) begin
          if (cmd_op == OP_MOV || cmd_op == OP_SWAP) state_n = S_RD_A;
          else                                       state_n = S_WR_B;
        end
      end
      S_RD_A:  state_n = (op_q == OP_SWAP) ? S_RD_B : S_WR_B;
      S_RD_B:  state_n = S_WR_A;
      S_WR_A:  state_n = S_WR_B;
      S_WR_B:  state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Output logic: values for the state being entered, registered below so they hold all cycle.
  always_comb begin
    src_sel_n  = 3'b000;
    dest_sel_n = 3'b000;
    data_n     = '0;
    done_n     = 1'b0;
    err_n      = accept && cmd_bad;
    case (state_n)
      S_RD_A: src_sel_n = eff_src;
      S_RD_B: src_sel_n = eff_dst;
      S_WR_A: begin
        dest_sel_n = eff_src;
        data_n     = tmp1_n;
      end
      S_WR_B: begin
        dest_sel_n = eff_dst;
        case (eff_op)
          OP_LDI:  data_n = eff_imm;
          OP_CLR:  data_n = '0;
          default: data_n = tmp0_n;
        endcase
      end
      S_DONE:  done_n = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_bus_selector  <= 3'b000;
      dest_bus_selector <= 3'b000;
      data              <= '0;
      done              <= 1'b0;
      err               <= 1'b0;
    end else begin
      src_bus_selector  <= src_sel_n;
      dest_bus_selector <= dest_sel_n;
      data              <= data_n;
      done              <= done_n;
      err               <= err_n;
    end
  end

  // Command latch and read temporaries
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q  <= OP_MOV;
      src_q <= 3'b000;
      dst_q <= 3'b000;
      imm_q <= '0;
      tmp0  <= '0;
      tmp1  <= '0;
    end else begin
      if (accept) begin
        op_q  <= cmd_op;
        src_q <= cmd_src;
        dst_q <= cmd_dst;
        imm_q <= cmd_imm;
      end
      tmp0 <= tmp0_n;
      tmp1 <= tmp1_n;
    end
  end

  // Completed-command counter, bumped on the edge that leaves DONE; wraps 255 -> 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xfer_count <= 8'd0;
    end else if (state == S_DONE) begin
      xfer_count <= xfer_count + 8'd1;
    end
  end

endmodule

// File: doc/bus_sequencer.md
BUS_SEQUENCER -- requirements
Module: bus_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, register/bus data width.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port cmd_valid  input  1  command offered.
REQ-005 SHALL have port cmd_ready  output  1  sequencer can accept a command.
REQ-006 SHALL have port cmd_op  input  2  00 MOV, 01 LDI, 10 SWAP, 11 CLR.
REQ-007 SHALL have port cmd_src  input  3  source selector for MOV, first register for SWAP.
REQ-008 SHALL have port cmd_dst  input  3  destination selector for MOV/LDI/CLR, second register for SWAP.
REQ-009 SHALL have port cmd_imm  input  WIDTH  immediate for LDI.
REQ-010 SHALL have port src_data  input  WIDTH  register-file read data for src_bus_selector.
REQ-011 SHALL have port src_bus_selector  output  3  register-file read select.
REQ-012 SHALL have port dest_bus_selector  output  3  register-file write select; 3'b000 = no write.
REQ-013 SHALL have port data  output  WIDTH  register-file write data.
REQ-014 SHALL have port done  output  1  one-cycle pulse when a command completes.
REQ-015 SHALL have port err  output  1  one-cycle pulse when a command is rejected.
REQ-016 SHALL have port xfer_count  output  8  count of completed commands.

Function
REQ-017 Selector codes SHALL be 3'b000 none, 3'b001 R0, 3'b010 R1, 3'b011 R2, 3'b100 R3; 3'b101-3'b111 invalid.
REQ-018 States SHALL be IDLE, RD_A, RD_B, WR_A, WR_B, DONE; cmd_ready SHALL be 1 only in IDLE.
REQ-019 A command SHALL be accepted on a rising edge with cmd_valid=1 and cmd_ready=1; cmd fields SHALL be latched then and ignored afterwards.
REQ-020 MOV SHALL sequence IDLE->RD_A (src_bus_selector=src, tmp0<=src_data at edge)->WR_B (dest_bus_selector=dst, data=tmp0)->DONE->IDLE.
REQ-021 LDI SHALL sequence IDLE->WR_B (dest_bus_selector=dst, data=imm)->DONE->IDLE.
REQ-022 CLR SHALL sequence IDLE->WR_B (dest_bus_selector=dst, data=0)->DONE->IDLE.
REQ-023 SWAP SHALL sequence RD_A (read src into tmp0)->RD_B (read dst into tmp1)->WR_A (write tmp1 to src)->WR_B (write tmp0 to dst)->DONE->IDLE.
REQ-024 In every state other than WR_A/WR_B, dest_bus_selector SHALL be 3'b000 and data SHALL be 0; outside RD_A/RD_B, src_bus_selector SHALL be 3'b000.
REQ-025 Selectors and data SHALL be registered outputs held stable for the whole state cycle; register file writes at the edge ending WR_A/WR_B.
REQ-026 done SHALL be 1 exactly during the DONE cycle; xfer_count SHALL increment by 1 on the edge leaving DONE, wrapping 255->0.
REQ-027 Latency accept-to-done SHALL be MOV 3, LDI 2, CLR 2, SWAP 5 cycles.
REQ-028 A command using an invalid selector in any field its op uses SHALL be accepted, cause no register access, stay in IDLE, pulse err the next cycle, and not increment xfer_count.
REQ-029 Unused fields (cmd_src for LDI/CLR, cmd_imm for non-LDI) SHALL not be checked.
REQ-030 SWAP with src==dst and MOV with src==dst SHALL run the full normal sequence.
REQ-031 After DONE, the next command SHALL be accepted no earlier than the following IDLE cycle (no back-to-back overlap).

Reset
REQ-032 reset=1 SHALL immediately force IDLE, src_bus_selector=0, dest_bus_selector=0, data=0, tmp0=tmp1=0, done=0, err=0, xfer_count=0, cmd_ready=1 after release.
REQ-033 reset mid-command SHALL abandon it with no further write and no done pulse.

Verification
REQ-034 LDI dst=001 imm=A5 -> one WR_B cycle with dest=001 data=A5, done next cycle, xfer_count=1.
REQ-035 R0=A5, R1=5A, SWAP src=001 dst=010 -> reads 001 then 010, writes 001<=5A then 010<=A5, done at cycle 5.
REQ-036 MOV src=011 dst=100 with R2=FF -> src=011 one cycle, then dest=100 data=FF, done at cycle 3.
REQ-037 LDI dst=110 -> cmd accepted, no write, err pulse, xfer_count unchanged, ready stays 1.
REQ-038 Assert reset during SWAP WR_A -> outputs zero immediately, R1 not written, no done, xfer_count=0.
REQ-039 Issue 256 CLR commands -> xfer_count wraps to 0, every done one cycle wide.
